cnt_burst_sched: RTL and testbench
==================================

// Module: cnt_burst_sched
// PURPOSE
//  Round-robin scheduler that shares the 8-bit counter datapath (enable-gated
//  incrementer r0 followed by a two-stage register pipeline to x) between
//  NREQ requesters. Each grant issues a burst of LEN enable pulses on cnt,
//  then waits out the pipeline latency so the final value is visible at x
//  before signalling done. It also keeps a shadow copy of the counter and
//  flags wrap-around.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  W     8  counter / burst-length width
//  LAT   3  clka edges from a cnt-high edge until the updated value appears at x
// PORTS
//  clka  in   1       clock; all state updates on posedge
//  rstn  in   1       asynchronous reset, active-low
//  req   in   NREQ    per-requester burst request, level
//  len   in   NREQ*W  burst length of requester i in len[i*W +: W]; sampled at grant
//  hold  in   1       stall: suppresses cnt and freezes the burst while high
//  gnt   out  NREQ    one-hot grant, registered
//  cnt   out  1       counter enable to the datapath
//  busy  out  1       high whenever state != IDLE
//  done  out  NREQ    one-cycle completion pulse for the granted requester
//  val   out  W       shadow counter, equals datapath r0
//  wrap  out  1       high in the cycle where cnt=1 and val is all-ones
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, gnt=0, done=0, cnt=0, busy=0,
//   val=0, wrap=0, rr pointer=0, remaining=0, drain counter=0.
//  States: IDLE, RUN, DRAIN.
//  IDLE: if |req, winner = first requester with req set, scanning from the
//   rr pointer upward with wrap modulo NREQ. Next edge: gnt=onehot(winner),
//   remaining=len[winner], rr pointer=winner+1 mod NREQ.
//   If len[winner]!=0 -> RUN; else -> DRAIN with drain counter=0.
//   No req -> stay in IDLE.
//  RUN: cnt = ~hold (combinational). Each edge with cnt=1: remaining-=1,
//   val+=1 mod 2^W. On the edge where remaining==1 and cnt=1 -> DRAIN,
//   drain counter=LAT-1. hold=1 freezes remaining and val, with no cnt pulse.
//  DRAIN: cnt=0, hold ignored. Drain counter decrements each edge.
//   When counter==0: done[winner]=1 for that cycle (gnt still high).
//   Next edge: gnt=0 -> IDLE.
//  Latency: grant edge to first cnt = 0 cycles (cnt high in the first RUN
//   cycle). Last cnt cycle to done cycle = LAT cycles. Every burst is followed
//   by at least one IDLE cycle.
//  req and len are ignored outside IDLE. Dropping req mid-burst does not abort
//   the burst; the burst completes and done still pulses.
//  Arithmetic: val and remaining are unsigned W bits. val wraps 2^W-1 -> 0,
//   and wrap is asserted in that cnt cycle. len=2^W-1 is legal.
//  Reset mid-burst: immediate return to reset values. No done pulse is
//   produced for the aborted burst.
//  gnt is always one-hot or zero. done is only ever set in the bit where gnt
//   is set.
// TESTING
//  1 req=0001, len0=3, hold=0 -> cnt high 3 cycles; done[0] 3 cycles after the
//    last cnt; val=3; gnt 0001 throughout RUN and DRAIN.
//  2 req=1111, all len=1, held high -> grant order 0,1,2,3,0; each burst gives
//    one cnt pulse; val increments by 1 per burst.
//  3 preload val=0xFE via earlier bursts, then len=3 -> val goes FF,00,01;
//    wrap=1 only in the cnt cycle with val=FF.
//  4 len=4, hold=1 for 2 cycles after the 2nd cnt -> exactly 4 cnt pulses over
//    6 RUN cycles; done delayed by 2 cycles.
//  5 len=0 on requester 2 -> no cnt; done[2] in the cycle after the grant; rr
//    pointer advances to 3.
//  6 rstn=0 during RUN with remaining=5 -> gnt, cnt, busy and val return to 0
//    at once; next request is arbitrated from pointer 0.

Source files
------------

// File: rtl/cnt_burst_sched.sv
// rtl/cnt_burst_sched.sv - round-robin burst scheduler for the shared counter datapath
// Grants one requester at a time, issues its burst of cnt pulses, then drains the pipeline.
module cnt_burst_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 3
) (
  input  logic              clka,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  input  logic              hold,
  output logic [NREQ-1:0]   gnt,
  output logic              cnt,
  output logic              busy,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      val,
  output logic              wrap
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_nx;
  logic [RW-1:0]   rr, rr_nx, win, cand;
  logic            found;
  logic [W-1:0]    rem, rem_nx, val_nx, win_len;
  logic [DW-1:0]   dcnt, dcnt_nx;
  logic [NREQ-1:0] gnt_nx;
  int              idx;

  // First requesting index at or after the rr pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = RW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_len = len[win*W +: W];

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      gnt   <= '0;
      rr    <= '0;
      rem   <= '0;
      dcnt  <= '0;
      val   <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      rr    <= rr_nx;
      rem   <= rem_nx;
      dcnt  <= dcnt_nx;
      val   <= val_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    rr_nx    = rr;
    rem_nx   = rem;
    dcnt_nx  = dcnt;
    val_nx   = val;
    cnt      = 1'b0;
    done     = '0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nx = NREQ'(1) << win;
          rem_nx = win_len;
          rr_nx  = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
          if (win_len != '0) begin
            state_nx = RUN;
          end else begin
            state_nx = DRAIN;
            dcnt_nx  = '0;
          end
        end
      end
      RUN: begin
        cnt = !hold;
        if (cnt) begin
          rem_nx = rem - 1'b1;
          val_nx = val + 1'b1;
          if (rem == W'(1)) begin
            state_nx = DRAIN;
            dcnt_nx  = DW'(LAT - 1);
          end
        end
      end
      DRAIN: begin
        if (dcnt == '0) begin
          done     = gnt;
          gnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          dcnt_nx = dcnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign wrap = cnt && (&val);

endmodule

// File: tb/tb_cnt_burst_sched.sv
// tb/tb_cnt_burst_sched.sv - self-checking bench for cnt_burst_sched
module tb_cnt_burst_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 3;
  localparam int BUDGET = 600;

  logic            clka = 1'b0;
  logic            rstn;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] len;
  logic            hold;
  logic [NREQ-1:0] gnt;
  logic            cnt;
  logic            busy;
  logic [NREQ-1:0] done;
  logic [W-1:0]    val;
  logic            wrap;

  cnt_burst_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clka(clka), .rstn(rstn), .req(req), .len(len), .hold(hold),
    .gnt(gnt), .cnt(cnt), .busy(busy), .done(done), .val(val), .wrap(wrap)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] len;
    int          hold_after;
    int          hold_len;
    int          win;
    logic [7:0]  val;
    int          wraps;
  } vec_t;

  typedef struct {
    logic [3:0] onehot;
    int         blen;
    logic [7:0] val;
    int         wraps;
    int         cycles;
  } exp_t;

  exp_t exp_q[$];
  vec_t vec[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic push_exp(input int win, input int blen, input logic [7:0] v,
                          input int wraps, input int hl);
    exp_t e;
    e.onehot = 4'b0001 << win;
    e.blen   = blen;
    e.val    = v;
    e.wraps  = wraps;
    e.cycles = (blen == 0) ? 1 : blen + hl + LAT;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  int cyc = 0, ncnt = 0, nwrap = 0, gstart = 0, last_cnt = 0;
  logic [3:0] prev_gnt = '0;
  always @(negedge clka) begin
    exp_t e;
    cyc++;
    if (!rstn) begin
      ncnt = 0;
      nwrap = 0;
      prev_gnt = '0;
    end else begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("done_within_gnt", 32'(done & ~gnt), 32'd0);
      if (gnt != 0 && prev_gnt == 0) gstart = cyc;
      if (cnt) begin
        ncnt++;
        last_cnt = cyc;
      end
      if (wrap) begin
        nwrap++;
        chk("wrap_val", 32'(val), 32'hFF);
      end
      if (done != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_bit", 32'(done), 32'(e.onehot));
          chk("gnt_at_done", 32'(gnt), 32'(e.onehot));
          chk("cnt_pulses", 32'(ncnt), 32'(e.blen));
          chk("val_at_done", 32'(val), 32'(e.val));
          chk("wrap_count", 32'(nwrap), 32'(e.wraps));
          chk("burst_cycles", 32'(cyc - gstart + 1), 32'(e.cycles));
          if (e.blen > 0) chk("last_cnt_to_done", 32'(cyc - last_cnt), 32'(LAT));
        end
        ncnt = 0;
        nwrap = 0;
      end
      prev_gnt = gnt;
    end
  end

  task automatic run_vec(input vec_t v);
    int ncyc = 0, nc = 0, hleft = v.hold_len;
    bit seen_g = 0, seen_d = 0;
    push_exp(v.win, int'(v.len[v.win*8 +: 8]), v.val, v.wraps, v.hold_len);
    @(posedge clka); #1;
    req = v.req;
    len = v.len;
    hold = 1'b0;
    forever begin
      @(negedge clka);
      ncyc++;
      if (cnt) nc++;
      if (hold) hleft--;
      if (gnt != 0) seen_g = 1;
      if (done != 0) seen_d = 1;
      if (seen_d && !busy) break;
      if (ncyc > BUDGET) begin
        chk("burst_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clka); #1;
      if (seen_g) req = '0;
      hold = (nc == v.hold_after) && (hleft > 0);
    end
    req = '0;
    hold = 1'b0;
  endtask

  initial begin
    vec_t rv;
    int ndone, ncyc, nc;
    rstn = 1'b0;
    req  = '0;
    len  = '0;
    hold = 1'b0;

    vec[0] = '{4'b0001, 32'h00000003, 0, 0, 0, 8'h08, 0};
    vec[1] = '{4'b0101, 32'h00020009, 0, 0, 2, 8'h0A, 0};
    vec[2] = '{4'b0011, 32'h00000401, 0, 0, 0, 8'h0B, 0};
    vec[3] = '{4'b0011, 32'h00000407, 2, 2, 1, 8'h0F, 0};
    vec[4] = '{4'b0100, 32'h01000303, 0, 0, 2, 8'h0F, 0};
    vec[5] = '{4'b1111, 32'h01010101, 0, 0, 3, 8'h10, 0};
    vec[6] = '{4'b1000, 32'hFF000000, 0, 0, 3, 8'h0F, 1};
    vec[7] = '{4'b0001, 32'h000000EF, 0, 0, 0, 8'hFE, 0};
    vec[8] = '{4'b0010, 32'h00000300, 0, 0, 1, 8'h01, 1};

    repeat (2) @(negedge clka);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_val", 32'(val), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    @(posedge clka); #1;
    rstn = 1'b1;

    // All requesters held high with len=1: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) push_exp(i % 4, 1, 8'(i + 1), 0, 0);
    @(posedge clka); #1;
    req = 4'b1111;
    len = 32'h01010101;
    ndone = 0;
    ncyc = 0;
    while (ndone < 5 && ncyc < BUDGET) begin
      @(negedge clka);
      ncyc++;
      if (done != 0) ndone++;
    end
    chk("rr_sequence_dones", 32'(ndone), 32'd5);
    @(posedge clka); #1;
    req = '0;
    repeat (2) @(posedge clka);

    for (int i = 0; i < 9; i++) run_vec(vec[i]);

    // Reset in the middle of a burst of 10 once 5 pulses have gone out.
    @(posedge clka); #1;
    req = 4'b0100;
    len = 32'h000A0000;
    nc = 0;
    ncyc = 0;
    while (nc < 5 && ncyc < BUDGET) begin
      @(negedge clka);
      ncyc++;
      if (cnt) nc++;
    end
    chk("pre_reset_pulses", 32'(nc), 32'd5);
    @(posedge clka); #1;
    rstn = 1'b0;
    req = '0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_val", 32'(val), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clka);
    #1;
    rstn = 1'b1;
    rv = '{4'b1010, 32'h01000100, 0, 0, 1, 8'h01, 0};
    run_vec(rv);

    repeat (3) @(negedge clka);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
